// File: rtl/ibex_wb_pkg.sv
// rtl/ibex_wb_pkg.sv - shared types and sizing helpers for the Ibex-to-Wishbone host bridge
package ibex_wb_pkg;

    typedef enum logic [1:0] {
        WbIdle,
        WbActive,
        WbAbort
    } wb_host_state_e;

    // Width of a counter that must hold every value 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ibex_wb_host_chan.sv
// rtl/ibex_wb_host_chan.sv - one host channel: req/gnt/rvalid to pipelined Wishbone with ack timeout
module ibex_wb_host_chan
    import ibex_wb_pkg::*;
#(
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2,
    parameter int TimeoutCycles  = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      host_req_i,
    output logic                      host_gnt_o,
    input  logic [AddressWidth-1:0]   host_addr_i,
    input  logic                      host_we_i,
    input  logic [DataWidth/8-1:0]    host_be_i,
    input  logic [DataWidth-1:0]      host_wdata_i,
    output logic                      host_rvalid_o,
    output logic [DataWidth-1:0]      host_rdata_o,
    output logic                      host_err_o,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [AddressWidth-1:0]   wb_addr_o,
    output logic [DataWidth-1:0]      wb_data_o,
    output logic [DataWidth/8-1:0]    wb_sel_o,
    input  logic                      wb_stall_i,
    input  logic                      wb_ack_i,
    input  logic [DataWidth-1:0]      wb_data_i,
    input  logic                      wb_err_i,
    output logic                      timeout_o
);

    localparam int OutW = cnt_width(MaxOutstanding);
    localparam logic [OutW-1:0] OutMax = OutW'(MaxOutstanding);

    wb_host_state_e r_state;
    wb_host_state_e w_state_nxt;
    logic [OutW-1:0] r_out;
    logic [OutW-1:0] w_out_nxt;

    logic w_active;
    logic w_busy;
    logic w_stb;
    logic w_gnt;
    logic w_rsp;
    logic w_drain;
    logic w_to_fire;

    assign w_active = (r_state != WbAbort);
    assign w_busy   = (r_out != '0);
    assign w_stb    = w_active & host_req_i & (r_out < OutMax);
    assign w_gnt    = w_stb & ~wb_stall_i;
    // Responses with nothing outstanding are spurious and must never reach the host.
    assign w_rsp    = w_active & w_busy & (wb_ack_i | wb_err_i);
    assign w_drain  = ~w_active & w_busy;

    generate
        if (TimeoutCycles > 0) begin : g_timer
            localparam int TmW = cnt_width(TimeoutCycles);
            logic [TmW-1:0] r_timer;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_timer <= '0;
                end else if (!w_active || !w_busy || w_rsp || w_gnt) begin
                    r_timer <= '0;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end

            assign w_to_fire = w_active & w_busy & ~w_rsp
                             & (r_timer == TmW'(TimeoutCycles - 1));
        end else begin : g_no_timer
            assign w_to_fire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= WbIdle;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        case (r_state)
            WbIdle, WbActive: begin
                w_out_nxt = r_out + OutW'(w_gnt) - OutW'(w_rsp);
                if (w_to_fire) begin
                    w_state_nxt = WbAbort;
                end else if (w_out_nxt != '0) begin
                    w_state_nxt = WbActive;
                end else begin
                    w_state_nxt = WbIdle;
                end
            end
            WbAbort: begin
                // Drain one errored response per cycle; the slave has already seen cyc drop.
                w_out_nxt = w_busy ? r_out - 1'b1 : '0;
                if (w_out_nxt == '0) begin
                    w_state_nxt = WbIdle;
                end
            end
            default: begin
                w_state_nxt = WbIdle;
                w_out_nxt   = '0;
            end
        endcase
    end

    // Every output is forced low while reset is held, even with a host still requesting.
    assign host_gnt_o    = rst_ni & w_gnt;
    assign wb_stb_o      = rst_ni & w_stb;
    assign wb_cyc_o      = rst_ni & w_active & (w_stb | w_busy);
    assign wb_we_o       = rst_ni & w_active & host_we_i;
    assign wb_addr_o     = (rst_ni & w_active) ? host_addr_i  : '0;
    assign wb_data_o     = (rst_ni & w_active) ? host_wdata_i : '0;
    assign wb_sel_o      = (rst_ni & w_active) ? host_be_i    : '0;
    assign host_rvalid_o = rst_ni & (w_rsp | w_drain);
    assign host_rdata_o  = (rst_ni & w_rsp) ? wb_data_i : '0;
    assign host_err_o    = rst_ni & ((w_rsp & wb_err_i) | w_drain);
    assign timeout_o     = rst_ni & w_to_fire;

endmodule

// File: rtl/ibex_wb_host_bridge.sv
// rtl/ibex_wb_host_bridge.sv - NrHosts Ibex host ports to flattened pipelined Wishbone masters
module ibex_wb_host_bridge
    import ibex_wb_pkg::*;
#(
    parameter int NrHosts        = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2,
    parameter int TimeoutCycles  = 256
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [AddressWidth-1:0]           host_addr_i  [NrHosts],
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [DataWidth/8-1:0]            host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]              host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [DataWidth-1:0]              host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]                host_err_o,
    output logic [NrHosts-1:0]                wb_cyc_o,
    output logic [NrHosts-1:0]                wb_stb_o,
    output logic [NrHosts-1:0]                wb_we_o,
    output logic [NrHosts*AddressWidth-1:0]   wb_addr_o,
    output logic [NrHosts*DataWidth-1:0]      wb_data_o,
    output logic [NrHosts*DataWidth/8-1:0]    wb_sel_o,
    input  logic [NrHosts-1:0]                wb_stall_i,
    input  logic [NrHosts-1:0]                wb_ack_i,
    input  logic [NrHosts*DataWidth-1:0]      wb_data_i,
    input  logic [NrHosts-1:0]                wb_err_i,
    output logic [NrHosts-1:0]                timeout_o
);

    localparam int SelW = DataWidth / 8;

    for (genvar h = 0; h < NrHosts; h++) begin : g_host
        ibex_wb_host_chan #(
            .DataWidth      (DataWidth),
            .AddressWidth   (AddressWidth),
            .MaxOutstanding (MaxOutstanding),
            .TimeoutCycles  (TimeoutCycles)
        ) u_chan (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .host_req_i    (host_req_i[h]),
            .host_gnt_o    (host_gnt_o[h]),
            .host_addr_i   (host_addr_i[h]),
            .host_we_i     (host_we_i[h]),
            .host_be_i     (host_be_i[h]),
            .host_wdata_i  (host_wdata_i[h]),
            .host_rvalid_o (host_rvalid_o[h]),
            .host_rdata_o  (host_rdata_o[h]),
            .host_err_o    (host_err_o[h]),
            .wb_cyc_o      (wb_cyc_o[h]),
            .wb_stb_o      (wb_stb_o[h]),
            .wb_we_o       (wb_we_o[h]),
            .wb_addr_o     (wb_addr_o[h*AddressWidth +: AddressWidth]),
            .wb_data_o     (wb_data_o[h*DataWidth +: DataWidth]),
            .wb_sel_o      (wb_sel_o[h*SelW +: SelW]),
            .wb_stall_i    (wb_stall_i[h]),
            .wb_ack_i      (wb_ack_i[h]),
            .wb_data_i     (wb_data_i[h*DataWidth +: DataWidth]),
            .wb_err_i      (wb_err_i[h]),
            .timeout_o     (timeout_o[h])
        );
    end

endmodule

// File: tb/tb_ibex_wb_host_bridge.sv
// tb/tb_ibex_wb_host_bridge.sv - directed self-checking bench for ibex_wb_host_bridge
module tb_ibex_wb_host_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we, stall, ack, werr;
    logic [31:0] addr  [2];
    logic [3:0]  be    [2];
    logic [31:0] wdata [2];
    logic [63:0] wb_rdata;
    logic [1:0]  gnt, rvalid, herr, cyc, stb, wbwe, tmo;
    logic [31:0] rdata [2];
    logic [63:0] wb_addr, wb_wdata;
    logic [7:0]  wb_sel;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ibex_wb_host_bridge #(
        .NrHosts        (2),
        .DataWidth      (32),
        .AddressWidth   (32),
        .MaxOutstanding (2),
        .TimeoutCycles  (8)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .host_req_i    (req),
        .host_gnt_o    (gnt),
        .host_addr_i   (addr),
        .host_we_i     (we),
        .host_be_i     (be),
        .host_wdata_i  (wdata),
        .host_rvalid_o (rvalid),
        .host_rdata_o  (rdata),
        .host_err_o    (herr),
        .wb_cyc_o      (cyc),
        .wb_stb_o      (stb),
        .wb_we_o       (wbwe),
        .wb_addr_o     (wb_addr),
        .wb_data_o     (wb_wdata),
        .wb_sel_o      (wb_sel),
        .wb_stall_i    (stall),
        .wb_ack_i      (ack),
        .wb_data_i     (wb_rdata),
        .wb_err_i      (werr),
        .timeout_o     (tmo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; we = '0; stall = '0; ack = '0; werr = '0;
        wb_rdata = '0;
        for (int h = 0; h < 2; h++) begin
            addr[h] = '0; be[h] = '0; wdata[h] = '0;
        end
        tick(); tick();
        settle();
        check("rst_cyc", cyc, 2'b00);
        check("rst_gnt", gnt, 2'b00);
        check("rst_rvalid", rvalid, 2'b00);
        check("rst_tmo", tmo, 2'b00);
        rst_n = 1'b1;
        tick();

        // 1: single read, ack two cycles after grant
        req[0] = 1'b1; addr[0] = 32'h0000_1000; be[0] = 4'hF;
        settle();
        check("t1_gnt", gnt[0], 1'b1);
        check("t1_cyc0", cyc[0], 1'b1);
        check("t1_addr", wb_addr[31:0], 64'h1000);
        tick();
        req[0] = 1'b0;
        settle();
        check("t1_cyc1", cyc[0], 1'b1);
        check("t1_stb1", stb[0], 1'b0);
        check("t1_nrv1", rvalid[0], 1'b0);
        tick();
        ack[0] = 1'b1; wb_rdata[31:0] = 32'hDEAD_BEEF;
        settle();
        check("t1_rvalid", rvalid[0], 1'b1);
        check("t1_rdata", rdata[0], 64'hDEAD_BEEF);
        check("t1_err", herr[0], 1'b0);
        tick();
        ack[0] = 1'b0;
        settle();
        check("t1_cyc3", cyc[0], 1'b0);
        check("t1_rdata0", rdata[0], 64'h0);

        // 2: stall holds the grant off while the address stays put
        tick();
        req[0] = 1'b1; addr[0] = 32'h0000_2004; stall[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t2_gnt_stall", gnt[0], 1'b0);
            check("t2_stb_stall", stb[0], 1'b1);
            check("t2_addr_stall", wb_addr[31:0], 64'h2004);
            tick();
        end
        stall[0] = 1'b0;
        settle();
        check("t2_gnt", gnt[0], 1'b1);
        tick();
        req[0] = 1'b0; ack[0] = 1'b1; wb_rdata[31:0] = 32'h1234_5678;
        settle();
        check("t2_rvalid", rvalid[0], 1'b1);
        check("t2_rdata", rdata[0], 64'h1234_5678);
        tick();
        ack[0] = 1'b0;
        settle();
        check("t2_cyc_end", cyc[0], 1'b0);

        // 3: outstanding limit of two, then grant and ack in the same cycle
        tick();
        req[0] = 1'b1; addr[0] = 32'h0000_3000;
        settle();
        check("t3_gnt0", gnt[0], 1'b1);
        tick();
        settle();
        check("t3_gnt1", gnt[0], 1'b1);
        tick();
        settle();
        check("t3_stb_full", stb[0], 1'b0);
        check("t3_gnt_full", gnt[0], 1'b0);
        check("t3_cyc_full", cyc[0], 1'b1);
        tick();
        tick();
        ack[0] = 1'b1; wb_rdata[31:0] = 32'hA5A5_0001;
        settle();
        check("t3_rv4", rvalid[0], 1'b1);
        check("t3_rd4", rdata[0], 64'hA5A5_0001);
        check("t3_gnt4", gnt[0], 1'b0);
        tick();
        wb_rdata[31:0] = 32'hA5A5_0002;
        settle();
        check("t3_gnt5", gnt[0], 1'b1);
        check("t3_rv5", rvalid[0], 1'b1);
        tick();
        req[0] = 1'b0; wb_rdata[31:0] = 32'hA5A5_0003;
        settle();
        check("t3_rv6", rvalid[0], 1'b1);
        check("t3_cyc6", cyc[0], 1'b1);
        tick();
        ack[0] = 1'b0;
        settle();
        check("t3_cyc7", cyc[0], 1'b0);

        // 4: ack timeout after eight cycles, errored drain, late ack ignored
        tick();
        req[0] = 1'b1; addr[0] = 32'h0000_4000;
        settle();
        check("t4_gnt", gnt[0], 1'b1);
        tick();
        req[0] = 1'b0;
        for (int c = 1; c < 8; c++) begin
            settle();
            check("t4_no_tmo", tmo[0], 1'b0);
            tick();
        end
        settle();
        check("t4_tmo", tmo[0], 1'b1);
        check("t4_cyc8", cyc[0], 1'b1);
        tick();
        req[0] = 1'b1; wb_rdata[31:0] = 32'hFFFF_FFFF;
        settle();
        check("t4_cyc_abort", cyc[0], 1'b0);
        check("t4_gnt_abort", gnt[0], 1'b0);
        check("t4_rv_abort", rvalid[0], 1'b1);
        check("t4_err_abort", herr[0], 1'b1);
        check("t4_rd_abort", rdata[0], 64'h0);
        check("t4_tmo_once", tmo[0], 1'b0);
        tick();
        req[0] = 1'b0; ack[0] = 1'b1;
        settle();
        check("t4_late_ack", rvalid[0], 1'b0);
        check("t4_cyc10", cyc[0], 1'b0);
        tick();
        ack[0] = 1'b0; wb_rdata = '0;

        // 5: bus error on a host 1 write, then a spurious ack
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0000_5008; be[1] = 4'h3;
        wdata[1] = 32'hCAFE_F00D;
        settle();
        check("t5_gnt", gnt, 2'b10);
        check("t5_we", wbwe[1], 1'b1);
        check("t5_sel", wb_sel[7:4], 64'h3);
        check("t5_wdata", wb_wdata[63:32], 64'hCAFE_F00D);
        check("t5_addr", wb_addr[63:32], 64'h5008);
        tick();
        req[1] = 1'b0; werr[1] = 1'b1;
        settle();
        check("t5_rvalid", rvalid[1], 1'b1);
        check("t5_err", herr[1], 1'b1);
        tick();
        werr[1] = 1'b0; ack[1] = 1'b1;
        settle();
        check("t5_spurious", rvalid[1], 1'b0);
        tick();
        ack[1] = 1'b0; we[1] = 1'b0;

        // 6: reset while two requests are outstanding
        req[0] = 1'b1; addr[0] = 32'h0000_6000;
        settle();
        check("t6_gnt0", gnt[0], 1'b1);
        tick();
        settle();
        check("t6_gnt1", gnt[0], 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_cyc", cyc, 2'b00);
        check("t6_rst_stb", stb, 2'b00);
        check("t6_rst_gnt", gnt, 2'b00);
        check("t6_rst_addr", wb_addr, 64'h0);
        tick();
        req[0] = 1'b0;
        rst_n = 1'b1;
        tick();
        ack = 2'b11; wb_rdata = 64'h1111_2222_3333_4444;
        settle();
        check("t6_no_stale", rvalid, 2'b00);
        check("t6_cyc_after", cyc, 2'b00);
        tick();
        ack = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
